// File: rtl/samsung_ir_tx_if.sv
// Command/status bundle between the key/command stage and the Samsung IR transmitter.
interface samsung_ir_tx_if;
  logic [31:0] command;
  logic        ir_out;
  logic        envelope;
  logic        busy;
  logic        done;

  modport master (
    output command,
    input  ir_out,
    input  envelope,
    input  busy,
    input  done
  );

  modport slave (
    input  command,
    output ir_out,
    output envelope,
    output busy,
    output done
  );
endinterface

// File: rtl/samsung_ir_tx.sv
// Samsung-format IR transmitter: leader, 32 pulse-distance bits (MSB first),
// stop mark and an enforced idle gap. Marks carry a 50% carrier; the raw
// envelope is exported alongside the modulated drive.
module samsung_ir_tx #(
  parameter int UNIT_CYCLES      = 28000,
  parameter int CARRIER_HALF     = 658,
  parameter int LEAD_UNITS       = 8,
  parameter int ONE_SPACE_UNITS  = 3,
  parameter int ZERO_SPACE_UNITS = 1,
  parameter int GAP_UNITS        = 80
) (
  input logic            clk,
  input logic            reset,
  samsung_ir_tx_if.slave bus
);

  localparam int CW  = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int CAW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam int M1  = (LEAD_UNITS > ONE_SPACE_UNITS) ? LEAD_UNITS : ONE_SPACE_UNITS;
  localparam int M2  = (ZERO_SPACE_UNITS > GAP_UNITS) ? ZERO_SPACE_UNITS : GAP_UNITS;
  localparam int MAX_UNITS = (M1 > M2) ? M1 : M2;
  localparam int UW  = $clog2(MAX_UNITS + 1);

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      shift_q, shift_d;
  logic [4:0]       bit_idx_q, bit_idx_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [UW-1:0]    unit_q, unit_d;
  logic [CAW-1:0]   car_cnt_q, car_cnt_d;
  logic             phase_q, phase_d;

  logic [UW-1:0]    state_units;
  logic             unit_end;
  logic             state_end;
  logic             mark_q;
  logic             mark_d;

  // State, counters, shift register and carrier phase registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      cyc_q     <= '0;
      unit_q    <= '0;
      car_cnt_q <= '0;
      phase_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      cyc_q     <= cyc_d;
      unit_q    <= unit_d;
      car_cnt_q <= car_cnt_d;
      phase_q   <= phase_d;
    end
  end

  // Length of the current state in units; a space after a '1' is longer.
  always_comb begin
    state_units = UW'(1);
    case (state_q)
      LEAD_MARK, LEAD_SPACE: state_units = UW'(LEAD_UNITS);
      BIT_SPACE:             state_units = shift_q[31] ? UW'(ONE_SPACE_UNITS)
                                                       : UW'(ZERO_SPACE_UNITS);
      GAP:                   state_units = UW'(GAP_UNITS);
      default:               state_units = UW'(1);
    endcase
  end

  assign unit_end  = (cyc_q == CW'(UNIT_CYCLES - 1));
  assign state_end = unit_end && (unit_q == state_units - UW'(1));

  // Next-state, unit timing and bit sequencing.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    cyc_d     = cyc_q;
    unit_d    = unit_q;

    if (state_q == IDLE) begin
      if (bus.command != 32'd0) begin
        state_d   = LEAD_MARK;
        shift_d   = bus.command;
        bit_idx_d = 5'd31;
        cyc_d     = '0;
        unit_d    = '0;
      end
    end else begin
      cyc_d  = unit_end ? '0 : cyc_q + CW'(1);
      unit_d = unit_end ? unit_q + UW'(1) : unit_q;
      if (state_end) begin
        cyc_d  = '0;
        unit_d = '0;
        case (state_q)
          LEAD_MARK:  state_d = LEAD_SPACE;
          LEAD_SPACE: state_d = BIT_MARK;
          BIT_MARK:   state_d = BIT_SPACE;
          BIT_SPACE: begin
            if (bit_idx_q == 5'd0) begin
              state_d = STOP_MARK;
            end else begin
              shift_d   = {shift_q[30:0], 1'b0};
              bit_idx_d = bit_idx_q - 5'd1;
              state_d   = BIT_MARK;
            end
          end
          STOP_MARK:  state_d = GAP;
          default:    state_d = IDLE;
        endcase
      end
    end
  end

  assign mark_q = (state_q == LEAD_MARK) || (state_q == BIT_MARK) || (state_q == STOP_MARK);
  assign mark_d = (state_d == LEAD_MARK) || (state_d == BIT_MARK) || (state_d == STOP_MARK);

  // Carrier: restart high at the first cycle of every mark, held low elsewhere.
  always_comb begin
    car_cnt_d = car_cnt_q;
    phase_d   = phase_q;
    if (!mark_d) begin
      car_cnt_d = '0;
      phase_d   = 1'b0;
    end else if (state_d != state_q) begin
      car_cnt_d = '0;
      phase_d   = 1'b1;
    end else if (car_cnt_q == CAW'(CARRIER_HALF - 1)) begin
      car_cnt_d = '0;
      phase_d   = ~phase_q;
    end else begin
      car_cnt_d = car_cnt_q + CAW'(1);
    end
  end

  // Outputs decode registered state only, so reset clears them at once.
  assign bus.envelope = mark_q;
  assign bus.ir_out   = mark_q & phase_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == GAP) && state_end;

endmodule

// File: tb/tb_samsung_ir_tx.sv
// Scoreboard bench for samsung_ir_tx with shortened unit and carrier timing.
module tb_samsung_ir_tx;
  localparam int UNIT = 4;
  localparam int HALF = 1;
  localparam int LEAD = 8;
  localparam int ONE  = 3;
  localparam int ZERO = 1;
  localparam int GAPU = 80;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  samsung_ir_tx_if bus ();

  samsung_ir_tx #(
    .UNIT_CYCLES(UNIT), .CARRIER_HALF(HALF), .LEAD_UNITS(LEAD),
    .ONE_SPACE_UNITS(ONE), .ZERO_SPACE_UNITS(ZERO), .GAP_UNITS(GAPU)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int start; int total; logic [31:0] cmd; } frame_t;
  typedef struct { logic level; int len; } seg_t;

  frame_t frame_q[$];
  seg_t   seg_q[$];

  int checks = 0;
  int errors = 0;
  int idle_bad = 0;

  function automatic void check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endfunction

  // Expected segment list of one frame: leader, bits MSB first, stop, gap.
  function automatic void push_frame(input logic [31:0] cmd, input int units, input int start);
    frame_t f;
    f.start = start;
    f.total = (units + GAPU) * UNIT;
    f.cmd   = cmd;
    frame_q.push_back(f);
    seg_q.push_back('{1'b1, LEAD * UNIT});
    seg_q.push_back('{1'b0, LEAD * UNIT});
    for (int i = 31; i >= 0; i--) begin
      seg_q.push_back('{1'b1, UNIT});
      seg_q.push_back('{1'b0, (cmd[i] ? ONE : ZERO) * UNIT});
    end
    seg_q.push_back('{1'b1, UNIT});
    seg_q.push_back('{1'b0, GAPU * UNIT});
  endfunction

  // ---------------- monitor ----------------
  logic   prev_busy = 1'b0;
  logic   cur_level = 1'b0;
  logic   have_exp  = 1'b0;
  logic   exp_ir;
  int     run_len = 0;
  int     car_bad = 0;
  int     done_cyc = -1;
  int     done_cnt = 0;
  frame_t cur_f;

  function automatic void close_seg();
    seg_t s;
    if (!have_exp) return;
    checks++;
    if (seg_q.size() == 0) begin
      errors++;
      $display("FAIL segment_extra: got level=%0d len=%0d expected none", cur_level, run_len);
      return;
    end
    s = seg_q.pop_front();
    if (s.level !== cur_level || s.len != run_len || car_bad != 0) begin
      errors++;
      $display("FAIL segment: got level=%0d len=%0d carrier_bad=%0d expected level=%0d len=%0d carrier_bad=0",
               cur_level, run_len, car_bad, s.level, s.len);
    end
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_busy = 1'b0;
        have_exp  = 1'b0;
      end else begin
        if (bus.busy && !prev_busy) begin
          done_cyc = -1;
          done_cnt = 0;
          if (frame_q.size() == 0) begin
            have_exp = 1'b0;
            check("unexpected_frame", 1, 0);
          end else begin
            cur_f    = frame_q.pop_front();
            have_exp = 1'b1;
            check("frame_start", cyc, cur_f.start);
          end
          cur_level = bus.envelope;
          run_len   = 0;
          car_bad   = 0;
        end
        if (bus.busy) begin
          if (bus.envelope !== cur_level) begin
            close_seg();
            cur_level = bus.envelope;
            run_len   = 0;
            car_bad   = 0;
          end
          exp_ir = cur_level && (((run_len / HALF) % 2) == 0);
          if (bus.ir_out !== exp_ir) car_bad++;
          run_len++;
          if (bus.done) begin
            done_cyc = cyc;
            done_cnt++;
          end
        end else begin
          if (prev_busy) begin
            close_seg();
            if (have_exp) begin
              check("done_cycle", done_cyc, cur_f.start + cur_f.total - 1);
              check("done_count", done_cnt, 1);
              check("busy_fall", cyc, cur_f.start + cur_f.total);
              $display("frame cmd=%08h start=%0d done=%0d busy_cycles=%0d",
                       cur_f.cmd, cur_f.start, done_cyc, cyc - cur_f.start);
            end
          end
          if (bus.envelope || bus.ir_out || bus.done) idle_bad++;
        end
        prev_busy = bus.busy;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [31:0] cmd, input int units, output int start);
    @(negedge clk);
    start = cyc + 1;
    bus.command = cmd;
    push_frame(cmd, units, start);
    @(negedge clk);
    bus.command = '0;
  endtask

  task automatic pulse_at(input int when, input logic [31:0] cmd);
    while (cyc < when) @(negedge clk);
    bus.command = cmd;
    @(negedge clk);
    bus.command = '0;
  endtask

  task automatic wait_idle(input int limit);
    int t;
    t = 0;
    while ((bus.busy || frame_q.size() != 0) && t < limit) begin
      @(negedge clk);
      t++;
    end
    check("wait_idle_timeout", int'(bus.busy || frame_q.size() != 0), 0);
    repeat (2) @(negedge clk);
  endtask

  logic [31:0] vec_cmd   [3] = '{32'h80000001, 32'hFFFFFFFF, 32'h00000001};
  int          vec_units [3] = '{85, 145, 83};

  initial begin
    int st;
    int bc;
    int t;
    bus.command = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_ir_out", int'(bus.ir_out), 0);
    check("reset_envelope", int'(bus.envelope), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame with requests injected mid-frame and during the gap.
    send(32'hE0E040BF, 109, st);
    pulse_at(st + 99, 32'h1);
    pulse_at(st + 499, 32'h1);
    wait_idle(2000);

    // Zero command held in idle.
    bc = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.busy) bc++;
    end
    check("idle_zero_command_busy", bc, 0);

    // Pulse-distance vectors.
    for (int i = 0; i < 3; i++) begin
      send(vec_cmd[i], vec_units[i], st);
      wait_idle(2000);
    end

    // Asynchronous reset in the middle of the first bit mark.
    send(32'hE0E040BF, 109, st);
    while (cyc < st + 64) @(negedge clk);
    check("bit_mark_ir_before_reset", int'(bus.ir_out), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_ir_out", int'(bus.ir_out), 0);
    check("async_reset_envelope", int'(bus.envelope), 0);
    check("async_reset_busy", int'(bus.busy), 0);
    frame_q.delete();
    seg_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    send(32'hE0E040BF, 109, st);
    wait_idle(2000);

    // Back-to-back: command on the done cycle is ignored, next cycle is accepted.
    send(32'h80000001, 85, st);
    t = 0;
    while (!bus.done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("done_wait_timeout", int'(bus.done), 1);
    bus.command = 32'hFFFFFFFF;
    @(negedge clk);
    check("busy_low_after_done", int'(bus.busy), 0);
    st = cyc + 1;
    bus.command = 32'hE0E040BF;
    push_frame(32'hE0E040BF, 109, st);
    @(negedge clk);
    bus.command = '0;
    wait_idle(2000);

    check("idle_outputs_clean", idle_bad, 0);
    check("scoreboard_empty", frame_q.size() + seg_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
